tick_rate_ctrl: RTL and testbench

Run-control and rate scheduler for the game timebase. Owns a single shared period counter and issues a one-cycle `tick` enable at one of four selectable rates (0.25/0.5/1/2 Hz at 50 MHz), replacing free-running per-rate dividers. Sits between the game sequencer, which starts, stops, pauses and speeds it up, and every block that steps on game beats (LED playback, timeout, score display).

---
 rtl/tick_rate_ctrl_pkg.sv | 24 ++
 rtl/tick_period_counter.sv | 42 ++++
 rtl/tick_rate_ctrl.sv | 123 ++++++++++++
 tb/tb_tick_rate_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_rate_ctrl_pkg.sv
// Shared types and helpers for the tick_rate_ctrl run-control block.
// Contents: FSM state enum, rate-code constants, period function P(r).
package tick_rate_ctrl_pkg;

   localparam int unsigned RATE_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [RATE_W-1:0] RATE_0P25 = 2'd0;
   localparam logic [RATE_W-1:0] RATE_0P5  = 2'd1;
   localparam logic [RATE_W-1:0] RATE_1    = 2'd2;
   localparam logic [RATE_W-1:0] RATE_2    = 2'd3;

   // Period in clock cycles for rate code r: (4*clk_hz) >> r
   function automatic int unsigned period(input logic [RATE_W-1:0] r,
                                          input int unsigned clk_hz);
      return (4 * clk_hz) >> r;
   endfunction

endpackage

// File: rtl/tick_period_counter.sv
// Loadable period counter shared by all rates.
// Ports: clk, rst_n (sync, active-low), clear (force 0), enable (count),
//        period (current period length), wrap_c (counter at period-1 and
//        enabled this cycle), half_c (next count lies in first half period).
module tick_period_counter #(
   parameter int unsigned CNT_W = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] period,
   output logic             wrap_c,
   output logic             half_c
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // Next count; clear dominates, wrap returns to 0
   always_comb begin
      wrap_c   = enable && !clear && (cnt == period - CNT_W'(1));
      cnt_next = cnt;
      if (clear || wrap_c) begin
         cnt_next = '0;
      end else if (enable) begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // Evaluated on the next count so the registered phase lines up with cnt
   assign half_c = (cnt_next < (period >> 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/tick_rate_ctrl.sv
// Run-control and rate scheduler for the game timebase: one shared period
// counter producing a one-cycle tick at 0.25/0.5/1/2 Hz.
// Ports: CLOCK_50, reset (sync, active-low), start, stop, pause (level),
//        rate_wr/rate_sel (load pending rate), level_up (pending +1, sat),
//        tick, phase, rate_cur, busy, beat_cnt (only with
//        TICK_RATE_CTRL_BEAT_CNT_EN defined).
module tick_rate_ctrl
   import tick_rate_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned CNT_W  = 28
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              rate_wr,
   input  logic [RATE_W-1:0] rate_sel,
   input  logic              level_up,
   output logic              tick,
   output logic              phase,
   output logic [RATE_W-1:0] rate_cur,
   output logic              busy
`ifdef TICK_RATE_CTRL_BEAT_CNT_EN
   ,
   output logic [7:0]        beat_cnt
`endif
);

   state_t            state;
   state_t            state_next;
   logic [RATE_W-1:0] pending;
   logic [RATE_W-1:0] pending_next;
   logic [CNT_W-1:0]  period_c;
   logic              start_edge_c;
   logic              clear_c;
   logic              enable_c;
   logic              wrap_c;
   logic              half_c;

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: stop > pause > start
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start && !stop && !pause) state_next = RUN;
         RUN:     if (stop) state_next = IDLE;
                  else if (pause) state_next = HOLD;
         HOLD:    if (stop) state_next = IDLE;
                  else if (!pause) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // Pending rate: write beats level_up; level_up saturates at the top code
   always_comb begin
      pending_next = pending;
      if (rate_wr) begin
         pending_next = rate_sel;
      end else if (level_up && (pending != RATE_2)) begin
         pending_next = pending + RATE_W'(1);
      end
   end

   assign start_edge_c = (state == IDLE) && (state_next == RUN);
   assign clear_c      = (state_next == IDLE) || start_edge_c;
   // Counting freezes on every edge where pause is high, so H paused
   // cycles shift later ticks by exactly H
   assign enable_c     = (state != IDLE) && (state_next == RUN);
   assign period_c     = CNT_W'(period(rate_cur, CLK_HZ));

   tick_period_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (CLOCK_50),
      .rst_n  (reset),
      .clear  (clear_c),
      .enable (enable_c),
      .period (period_c),
      .wrap_c (wrap_c),
      .half_c (half_c)
   );

   // Registered outputs; rate changes land only on start or period wrap
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         pending  <= RATE_0P25;
         rate_cur <= RATE_0P25;
         tick     <= 1'b0;
         phase    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         pending <= pending_next;
         tick    <= wrap_c;
         phase   <= (state_next != IDLE) && half_c;
         busy    <= (state_next != IDLE);
         if (start_edge_c || wrap_c) begin
            rate_cur <= pending;
         end
      end
   end

`ifdef TICK_RATE_CTRL_BEAT_CNT_EN
   // Beat counter, cleared on start/stop, frozen in HOLD
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         beat_cnt <= 8'd0;
      end else if (clear_c) begin
         beat_cnt <= 8'd0;
      end else if (wrap_c) begin
         beat_cnt <= beat_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Self-checking bench for tick_rate_ctrl with CLK_HZ=16 (P = 64/32/16/8).
// Vector table, directed corner sequences and random stimulus, all checked
// against a cycle-level behavioural model.
module tb_tick_rate_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       pause;
   logic       rate_wr;
   logic [1:0] rate_sel;
   logic       level_up;
   logic       tick;
   logic       phase;
   logic [1:0] rate_cur;
   logic       busy;
`ifdef TICK_RATE_CTRL_BEAT_CNT_EN
   logic [7:0] beat_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   tick_rate_ctrl #(.CLK_HZ(16), .CNT_W(8)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .rate_wr  (rate_wr),
      .rate_sel (rate_sel),
      .level_up (level_up),
      .tick     (tick),
      .phase    (phase),
      .rate_cur (rate_cur),
      .busy     (busy)
`ifdef TICK_RATE_CTRL_BEAT_CNT_EN
      ,
      .beat_cnt (beat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: running flag, cycles elapsed in the current period
   int m_active, m_elapsed, m_rate, m_pend, m_beats, m_tick;

   function automatic int per(input int r);
      return 64 >> r;
   endfunction

   task automatic model_step(input int st, sp, pa, rw, rs, lu);
      int old_pend;
      old_pend = m_pend;
      m_tick   = 0;
      if (!reset) begin
         m_active = 0; m_elapsed = 0; m_rate = 0; m_pend = 0; m_beats = 0;
      end else begin
         if (rw != 0)                    m_pend = rs;
         else if (lu != 0 && m_pend < 3) m_pend = m_pend + 1;
         if (m_active == 0) begin
            if (st != 0 && sp == 0 && pa == 0) begin
               m_active = 1; m_elapsed = 0; m_beats = 0; m_rate = old_pend;
            end
         end else if (sp != 0) begin
            m_active = 0; m_elapsed = 0; m_beats = 0;
         end else if (pa == 0) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == per(m_rate)) begin
               m_tick = 1; m_elapsed = 0;
               m_beats = (m_beats + 1) % 256;
               m_rate = old_pend;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive, update model at the edge, compare 1 time unit later
   task automatic step(input logic st, sp, pa, rw, input logic [1:0] rs,
                       input logic lu);
      start = st; stop = sp; pause = pa; rate_wr = rw; rate_sel = rs;
      level_up = lu;
      @(posedge clk);
      model_step(int'(st), int'(sp), int'(pa), int'(rw), int'(rs), int'(lu));
      #1;
      chk("model_tick", int'(tick), m_tick);
      chk("model_busy", int'(busy), m_active);
      chk("model_phase", int'(phase),
          (m_active != 0 && m_elapsed < per(m_rate) / 2) ? 1 : 0);
      chk("model_rate_cur", int'(rate_cur), m_rate);
`ifdef TICK_RATE_CTRL_BEAT_CNT_EN
      chk("model_beat_cnt", int'(beat_cnt), m_beats);
`endif
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
   endtask

   typedef struct {
      logic       st, sp, pa, rw;
      logic [1:0] rs;
      logic       lu;
      logic       e_tick, e_busy, e_phase;
      logic [1:0] e_rate;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, sp, pa, rw, input logic [1:0] rs,
                      input logic lu, input logic et, eb, ep,
                      input logic [1:0] er);
      vec_t v;
      v.st = st; v.sp = sp; v.pa = pa; v.rw = rw; v.rs = rs; v.lu = lu;
      v.e_tick = et; v.e_busy = eb; v.e_phase = ep; v.e_rate = er;
      vecs.push_back(v);
   endtask

   initial begin
      int first_k, second_k;
      logic pz;

      reset = 1'b0;
      start = 0; stop = 0; pause = 0; rate_wr = 0; rate_sel = 0; level_up = 0;
      m_active = 0; m_elapsed = 0; m_rate = 0; m_pend = 0; m_beats = 0; m_tick = 0;

      // Reset state
      idle_step();
      idle_step();
      chk("reset_tick", int'(tick), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_phase", int'(phase), 0);
      chk("reset_rate", int'(rate_cur), 0);
      reset = 1'b1;

      // Vector table
      add(0,0,0,1,2'd3,0, 0,0,0,2'd3 & 2'd0);
      add(1,0,0,0,2'd0,0, 0,1,1,2'd3);
      for (int i = 1; i <= 3; i++) add(0,0,0,0,2'd0,0, 0,1,1,2'd3);
      for (int i = 4; i <= 7; i++) add(0,0,0,0,2'd0,0, 0,1,0,2'd3);
      add(0,0,0,0,2'd0,0, 1,1,1,2'd3);
      add(1,1,1,0,2'd0,0, 0,0,0,2'd3);
      add(1,1,1,0,2'd0,0, 0,0,0,2'd3);
      add(0,0,0,1,2'd2,0, 0,0,0,2'd3);
      add(0,0,0,1,2'd1,1, 0,0,0,2'd3);
      add(1,0,0,0,2'd0,0, 0,1,1,2'd1);
      add(0,1,0,0,2'd0,0, 0,0,0,2'd1);
      for (int i = 0; i < 3; i++) add(0,0,0,0,2'd0,1, 0,0,0,2'd1);
      add(1,0,0,0,2'd0,0, 0,1,1,2'd3);
      add(0,1,0,0,2'd0,0, 0,0,0,2'd3);
      foreach (vecs[i]) begin
         step(vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].rw, vecs[i].rs, vecs[i].lu);
         chk($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].e_tick));
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
         chk($sformatf("vec%0d_phase", i), int'(phase), int'(vecs[i].e_phase));
         chk($sformatf("vec%0d_rate", i), int'(rate_cur), int'(vecs[i].e_rate));
      end

      // Rate 2 with level_up mid-period: period kept, next period 8
      step(0,0,0,1,2'd2,0);
      step(1,0,0,0,2'd0,0);
      first_k = -1; second_k = -1;
      for (int k = 1; k <= 30; k++) begin
         step(0,0,0,0,2'd0, k == 5);
         if (tick && first_k < 0) first_k = k;
         else if (tick && second_k < 0) second_k = k;
         if (k == 16) chk("lvl_rate_at_tick", int'(rate_cur), 3);
      end
      chk("lvl_first_tick", first_k, 16);
      chk("lvl_second_tick", second_k, 24);
      step(0,1,0,0,2'd0,0);

      // Pause 10 cycles from cycle 3 at rate 3 delays first tick by 10
      step(0,0,0,1,2'd3,0);
      step(1,0,0,0,2'd0,0);
      first_k = -1;
      for (int k = 1; k <= 30; k++) begin
         step(0,0, k >= 3 && k <= 12, 0,2'd0,0);
         if (tick && first_k < 0) first_k = k;
         if (k >= 3 && k <= 12) begin
            chk("hold_phase", int'(phase), 1);
            chk("hold_busy", int'(busy), 1);
         end
      end
      chk("pause_first_tick", first_k, 18);
      step(0,1,0,0,2'd0,0);

      // Stop on the cycle before a tick
      step(1,0,0,0,2'd0,0);
      for (int k = 1; k <= 7; k++) idle_step();
      step(0,1,0,0,2'd0,0);
      chk("stop_tick", int'(tick), 0);
      chk("stop_busy", int'(busy), 0);
      chk("stop_phase", int'(phase), 0);
`ifdef TICK_RATE_CTRL_BEAT_CNT_EN
      chk("stop_beat_cnt", int'(beat_cnt), 0);
`endif
      idle_step();
      chk("stop_no_late_tick", int'(tick), 0);

      // Randomized run against the model
      pz = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         logic st, sp, rw, lu;
         if ($urandom_range(0, 5) == 0) pz = ~pz;
         st = ($urandom_range(0, 7) == 0) && !pz;
         sp = ($urandom_range(0, 59) == 0);
         rw = ($urandom_range(0, 19) == 0);
         lu = ($urandom_range(0, 19) == 0);
         step(st, sp, pz, rw, 2'($urandom_range(0, 3)), lu);
      end
      step(0,1,0,0,2'd0,0);

      // Reset mid-operation clears pending and current rate
      step(0,0,0,1,2'd3,0);
      step(1,0,0,0,2'd0,0);
      for (int k = 0; k < 5; k++) idle_step();
      reset = 1'b0;
      idle_step();
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_rate", int'(rate_cur), 0);
      reset = 1'b1;
      step(1,0,0,0,2'd0,0);
      chk("rst_pending_cleared", int'(rate_cur), 0);
      step(0,1,0,0,2'd0,0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
